// File: rtl/bsc_pkg.sv
// Shared constants and next-step helper for the bounce/rotate scanning counter.
package bsc_pkg;

    localparam logic MODE_BOUNCE = 1'b0;
    localparam logic MODE_ROTATE = 1'b1;
    localparam logic DIR_UP      = 1'b1;
    localparam logic DIR_DOWN    = 1'b0;

    typedef struct packed {
        logic [31:0] pos;
        logic        dir;
        logic        end_hit;
    } step_t;

    // One step of the scan from (pos, dir) for a vector of the given width.
    function automatic step_t next_step(input logic [31:0] pos, input logic dir,
                                        input logic mode, input logic [31:0] width);
        step_t s;
        logic  d;
        d         = dir;
        s.end_hit = 1'b0;
        if (mode == MODE_BOUNCE) begin
            // Sitting at an end facing outward (e.g. after leaving rotate): turn first.
            if (d == DIR_UP && pos == width - 1) begin
                d = DIR_DOWN;
            end else if (d == DIR_DOWN && pos == 32'd0) begin
                d = DIR_UP;
            end
            s.pos = (d == DIR_UP) ? pos + 32'd1 : pos - 32'd1;
            s.dir = d;
            if (s.pos == width - 1) begin
                s.dir     = DIR_DOWN;
                s.end_hit = 1'b1;
            end else if (s.pos == 32'd0) begin
                s.dir     = DIR_UP;
                s.end_hit = 1'b1;
            end
        end else begin
            s.dir = dir;
            if (dir == DIR_UP) begin
                s.end_hit = (pos == width - 1);
                s.pos     = s.end_hit ? 32'd0 : pos + 32'd1;
            end else begin
                s.end_hit = (pos == 32'd0);
                s.pos     = s.end_hit ? width - 1 : pos - 32'd1;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/bounce_shift_counter_if.sv
// Control and status bundle of the scanning counter.
interface bounce_shift_counter_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned PW = $clog2(WIDTH);

    logic             en;
    logic             mode;
    logic             load;
    logic [PW-1:0]    load_pos;
    logic [WIDTH-1:0] count;
    logic [PW-1:0]    pos;
    logic             dir;
    logic             end_pulse;

    modport master (
        output en, mode, load, load_pos,
        input  count, pos, dir, end_pulse
    );

    modport slave (
        input  en, mode, load, load_pos,
        output count, pos, dir, end_pulse
    );

endinterface

// File: rtl/bsc_prescaler.sv
// Counts enabled cycles modulo DIV; tick marks the enabled cycle that wraps.
module bsc_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic tick
);
    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    // Next count: clear wins, otherwise advance on enabled cycles and wrap at DIV-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bounce_shift_counter.sv
// One-hot scanning counter (bounce or rotate) with load and end-of-travel pulse.
// Define BSC_PRESCALE_EN to step only every DIV enabled cycles.
module bounce_shift_counter
    import bsc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4
) (
    input logic                   clk,
    input logic                   reset,
    bounce_shift_counter_if.slave bus
);
    localparam int unsigned PW = $clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > 64 || DIV < 1 || DIV > 65535) begin : g_bad_param
        $error("bounce_shift_counter: WIDTH or DIV out of range");
    end

    logic [PW-1:0] pos_q, pos_d, ld_pos;
    logic          dir_q, dir_d;
    logic          end_q, end_d;
    logic          tick;
    step_t         nxt;
    logic          unused_step_hi;

`ifdef BSC_PRESCALE_EN
    logic step_en;
    assign step_en = bus.en && !bus.load;

    bsc_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (step_en),
        .clear(bus.load),
        .tick (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign unused_step_hi = ^nxt.pos[31:PW];

    // Next state: load beats stepping; end_pulse only follows a step that hit an end.
    always_comb begin
        nxt    = next_step(32'(pos_q), dir_q, bus.mode, 32'(WIDTH));
        ld_pos = (32'(bus.load_pos) > WIDTH - 1) ? PW'(WIDTH - 1) : bus.load_pos;
        pos_d  = pos_q;
        dir_d  = dir_q;
        end_d  = 1'b0;
        if (bus.load) begin
            pos_d = ld_pos;
            if (bus.mode == MODE_BOUNCE) begin
                if (32'(ld_pos) == WIDTH - 1) begin
                    dir_d = DIR_DOWN;
                end else if (ld_pos == '0) begin
                    dir_d = DIR_UP;
                end
            end
        end else if (bus.en && tick) begin
            pos_d = PW'(nxt.pos);
            dir_d = nxt.dir;
            end_d = nxt.end_hit;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q <= '0;
            dir_q <= DIR_UP;
            end_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
            end_q <= end_d;
        end
    end

    assign bus.pos       = pos_q;
    assign bus.count     = WIDTH'(1) << pos_q;
    assign bus.dir       = dir_q;
    assign bus.end_pulse = end_q;

endmodule
